// File: rtl/sysbus_mem_pkg.sv
// sysbus_mem_pkg: shared address-width derivation, memory FSM states and parity helper
package sysbus_mem_pkg;
  typedef enum logic {CLEAR, IDLE} state_t;
  function automatic int addr_w(input int word_w, input int op_w);
    return word_w - op_w;
  endfunction
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/sysbus_ram_array.sv
// sysbus_ram_array: sync-write word storage with optional parity column (SYSBUS_RAM_PARITY_EN)
module sysbus_ram_array
  import sysbus_mem_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
`ifdef SYSBUS_RAM_PARITY_EN
  ,
  output logic              rerr
`endif
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
`ifdef SYSBUS_RAM_PARITY_EN
  logic par [DEPTH];
  always_ff @(posedge clk) if (we) par[waddr] <= parity(64'(wdata));
  assign rerr = par[raddr] != parity(64'(rdata));
`endif
endmodule

// File: rtl/sysbus_ram.sv
// sysbus_ram: upper-half sysbus data RAM with MAR/MDR, clear sweep, ready; parity via SYSBUS_RAM_PARITY_EN
module sysbus_ram
  import sysbus_mem_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 2 ** (addr_w(WORD_W, OP_W) - 1)
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              MDR_bus,
  input  logic              load_MDR,
  input  logic              load_MAR,
  input  logic              CS,
  input  logic              R_NW,
  output logic              ready,
  output logic              parity_err,
  inout  wire  [WORD_W-1:0] sysbus
);
  localparam int ADDR_W = addr_w(WORD_W, OP_W);
  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  state_t state;
  logic [ADDR_W-1:0] mar;
  logic [WORD_W-1:0] mdr, rdata, wdata;
  logic [IDX_W-1:0] cnt, idx, waddr;
  logic sel, in_rng, rd, wr, we;
  assign sel = mar[ADDR_W-1];
  assign idx = mar[IDX_W-1:0];
  assign in_rng = {1'b0, idx} < (IDX_W+1)'(DEPTH);
  assign rd = state == IDLE && CS && R_NW && sel;
  assign wr = state == IDLE && CS && !R_NW && sel && in_rng;
  assign we = state == CLEAR || wr;
  assign waddr = state == CLEAR ? cnt : idx;
  assign wdata = state == CLEAR ? '0 : mdr;
  assign sysbus = MDR_bus && sel ? mdr : 'z;
`ifdef SYSBUS_RAM_PARITY_EN
  logic rerr;
`endif
  sysbus_ram_array #(.WORD_W(WORD_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk(clock),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(idx),
    .rdata(rdata)
`ifdef SYSBUS_RAM_PARITY_EN
    ,
    .rerr(rerr)
`endif
  );
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      mar <= '0;
      mdr <= '0;
      ready <= 1'b0;
      state <= CLEAR;
      cnt <= '0;
    end else begin
      if (load_MAR) mar <= sysbus[ADDR_W-1:0];
      if (load_MDR) mdr <= sysbus;
      else if (rd) mdr <= in_rng ? rdata : '0;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          ready <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
`ifdef SYSBUS_RAM_PARITY_EN
  always_ff @(posedge clock) begin
    if (!n_reset) parity_err <= 1'b0;
    else if (rd && !load_MDR) parity_err <= in_rng && rerr;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sysbus_ram.sv
// tb_sysbus_ram: directed self-checking bench for sysbus_ram
module tb_sysbus_ram;
  logic clock = 1'b0;
  logic n_reset, MDR_bus, load_MDR, load_MAR, CS, R_NW;
  logic ready, parity_err;
  logic [7:0] drv, v;
  logic drv_en;
  wire [7:0] sysbus;
  int checks = 0;
  int errors = 0;
  int n;
  assign sysbus = drv_en ? drv : 8'hzz;
  always #5 clock = ~clock;
  sysbus_ram dut (
    .clock(clock),
    .n_reset(n_reset),
    .MDR_bus(MDR_bus),
    .load_MDR(load_MDR),
    .load_MAR(load_MAR),
    .CS(CS),
    .R_NW(R_NW),
    .ready(ready),
    .parity_err(parity_err),
    .sysbus(sysbus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    {MDR_bus, load_MDR, load_MAR, CS, R_NW} = '0;
    drv_en = 1'b0;
    drv = 8'h00;
  endtask
  task automatic set_mar(input logic [7:0] a);
    idle();
    drv = a;
    drv_en = 1'b1;
    load_MAR = 1'b1;
    cyc();
    idle();
  endtask
  task automatic set_mdr(input logic [7:0] d);
    idle();
    drv = d;
    drv_en = 1'b1;
    load_MDR = 1'b1;
    cyc();
    idle();
  endtask
  task automatic mem_wr();
    idle();
    CS = 1'b1;
    cyc();
    idle();
  endtask
  task automatic mem_rd();
    idle();
    CS = 1'b1;
    R_NW = 1'b1;
    cyc();
    idle();
  endtask
  task automatic bus_val(output logic [7:0] r);
    idle();
    MDR_bus = 1'b1;
    #1;
    r = sysbus;
    idle();
  endtask
  task automatic bus_hiz(input string tag);
    idle();
    MDR_bus = 1'b1;
    drv_en = 1'b1;
    drv = 8'h00;
    #1;
    chk(tag, sysbus, 8'h00);
    idle();
  endtask
  task automatic rd_word(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] r;
    set_mar(a);
    mem_rd();
    bus_val(r);
    chk(tag, r, exp);
  endtask
  task automatic wr_word(input logic [7:0] a, input logic [7:0] d);
    set_mar(a);
    set_mdr(d);
    mem_wr();
  endtask
  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready && n < 100) begin
      cyc();
      n++;
    end
    chk(tag, n, 16);
  endtask
  initial begin
    idle();
    n_reset = 1'b0;
    cyc();
    cyc();
    chk("rst_ready", ready, 0);
    chk("rst_perr", parity_err, 0);
    bus_hiz("rst_hiz");
    n_reset = 1'b1;
    wait_ready("clear_len");
    chk("ready_hold", ready, 1);
    for (int i = 0; i < 16; i++) rd_word("clear_word", 8'h10 + 8'(i), 8'h00);
    wr_word(8'h13, 8'hA5);
    set_mdr(8'h00);
    rd_word("wr_rd_13", 8'h13, 8'hA5);
    wr_word(8'h1A, 8'h77);
    wr_word(8'h1F, 8'hC3);
    rd_word("wr_rd_1f", 8'h1F, 8'hC3);
    rd_word("wr_rd_1a", 8'h1A, 8'h77);
    set_mdr(8'h5E);
    set_mar(8'h05);
    mem_wr();
    mem_rd();
    bus_hiz("sel0_hiz");
    set_mar(8'h15);
    bus_val(v);
    chk("sel0_mdr", v, 8'h5E);
    mem_rd();
    bus_val(v);
    chk("sel0_mem", v, 8'h00);
    set_mar(8'h1A);
    drv = 8'h3C;
    drv_en = 1'b1;
    load_MDR = 1'b1;
    CS = 1'b1;
    R_NW = 1'b1;
    cyc();
    idle();
    bus_val(v);
    chk("ldmdr_rd", v, 8'h3C);
    rd_word("ldmdr_rd_mem", 8'h1A, 8'h77);
    set_mdr(8'h11);
    drv = 8'h22;
    drv_en = 1'b1;
    load_MDR = 1'b1;
    CS = 1'b1;
    cyc();
    idle();
    bus_val(v);
    chk("ldmdr_wr_mdr", v, 8'h22);
    rd_word("ldmdr_wr_mem", 8'h1A, 8'h11);
    drv = 8'h13;
    drv_en = 1'b1;
    load_MAR = 1'b1;
    CS = 1'b1;
    R_NW = 1'b1;
    cyc();
    idle();
    bus_val(v);
    chk("ldmar_old", v, 8'h11);
    mem_rd();
    bus_val(v);
    chk("ldmar_new", v, 8'hA5);
    n_reset = 1'b0;
    cyc();
    n_reset = 1'b1;
    chk("rst2_ready", ready, 0);
    for (int i = 0; i < 7; i++) cyc();
    chk("mid_ready", ready, 0);
    n_reset = 1'b0;
    cyc();
    chk("mid_rst_ready", ready, 0);
    n_reset = 1'b1;
    wait_ready("mid_clear_len");
    rd_word("post_13", 8'h13, 8'h00);
    rd_word("post_1a", 8'h1A, 8'h00);
    rd_word("post_1f", 8'h1F, 8'h00);
`ifdef SYSBUS_RAM_PARITY_EN
    wr_word(8'h12, 8'h5A);
    wr_word(8'h13, 8'h0F);
    dut.u_array.par[2] = ~dut.u_array.par[2];
    rd_word("par_rd2", 8'h12, 8'h5A);
    chk("par_err2", parity_err, 1);
    rd_word("par_rd3", 8'h13, 8'h0F);
    chk("par_err3", parity_err, 0);
`else
    chk("par_tied", parity_err, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
